boot_frame_ctrl: RTL and testbench
==================================

Name: boot_frame_ctrl

Overview:
- Sequences the UART receive datapath during bootstrap.
- Consumes the per-byte strobe, data and timeout from the UART receiver, and parses a framed image: sync byte, 16-bit little-endian length, payload, 8-bit checksum.
- Writes the payload sequentially into an on-chip byte memory.
- Reports done or error to the top-level boot sequencer.

Parameters:
- ADDR_W, 8, width of memory write address.
- MAX_LEN, 256, largest accepted payload length in bytes; must be ≤ 2**ADDR_W.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock (1 MHz).
- n_rst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; arms the controller to hunt for a frame.
- byte_valid  input  1  one-cycle strobe; byte_data holds a new received byte.
- byte_data  input  8  received byte, valid only when byte_valid=1.
- rx_timeout  input  1  level; receiver idle timeout has occurred.
- mem_we  output  1  memory write enable, one cycle per payload byte.
- mem_addr  output  ADDR_W  write address, 0-based payload index.
- mem_wdata  output  8  write data.
- busy  output  1  high in SYNC through CSUM.
- done  output  1  frame accepted; sticky.
- error  output  1  frame rejected; sticky.
- err_code  output  2  0 none, 1 bad length, 2 timeout, 3 checksum mismatch.
- length  output  16  captured payload length; valid from PAYLOAD onward.

Behaviour:
- Reset (async, n_rst=0): state IDLE; all outputs 0; internal length, index and checksum registers 0.
- States: IDLE, SYNC, LEN_LO, LEN_HI, PAYLOAD, CSUM, DONE, ERROR.
- IDLE: start → SYNC. byte_valid is ignored.
- SYNC:
  - byte_valid with byte_data==SYNC_BYTE → LEN_LO.
  - Any other byte is discarded; stay in SYNC.
  - rx_timeout is ignored in SYNC.
- LEN_LO: on byte_valid, capture length[7:0] → LEN_HI.
- LEN_HI: on byte_valid, capture length[15:8]. Using the assembled value:
  - If it is 0 or > MAX_LEN → ERROR, err_code=1.
  - Otherwise → PAYLOAD; index=0; checksum=0.
- PAYLOAD, per byte_valid:
  - Next cycle: mem_we=1, mem_addr=index, mem_wdata=byte_data (registered, latency 1).
  - checksum += byte_data (mod 256); index++.
  - When the byte just accepted is index==length-1 → CSUM.
- CSUM: on byte_valid:
  - If (checksum + byte_data) mod 256 == 0 → DONE.
  - Otherwise → ERROR, err_code=3.
  - The checksum byte is never written to memory.
- Timeout: rx_timeout=1 in LEN_LO, LEN_HI, PAYLOAD or CSUM → ERROR, err_code=2.
  - If byte_valid and rx_timeout are high in the same cycle, timeout wins; the byte is dropped and not written.
- DONE and ERROR are terminal.
  - done/error are registered and asserted the cycle after entry, then held.
  - byte_valid and rx_timeout are ignored.
  - start → SYNC; clears done, error, err_code; length is retained until the next LEN_HI.
- start while busy is ignored; the frame in progress is not disturbed.
- busy = state ∈ {SYNC, LEN_LO, LEN_HI, PAYLOAD, CSUM}, registered with the state.
- mem_we is never asserted outside the cycle after an accepted PAYLOAD byte. mem_addr/mem_wdata hold their last value when mem_we=0.
- Widths:
  - index is ADDR_W+1 bits internally, so length==2**ADDR_W is representable.
  - mem_addr = index[ADDR_W-1:0]; it never wraps within a legal frame.
- Reset mid-frame: returns to IDLE immediately. Partially written memory contents are not cleared.

Test Plan:
- Good frame: start; bytes A5,03,00,10,20,30,A0 → mem writes (0,10),(1,20),(2,30); done=1, err_code=0, length=3.
- Sync hunt: start; bytes 00,FF,A5,01,00,7F,81 → leading 00/FF produce no writes; one write (0,7F); done=1.
- Bad checksum: start; A5,02,00,01,02,00 → two writes; error=1, err_code=3, done=0.
- Bad length: start; A5,01,01 (257 > MAX_LEN=256) → error=1, err_code=1, no writes. Separately, A5,00,00 → err_code=1.
- Timeout: start; A5,04,00,11, then rx_timeout=1 → one write (0,11); error=1, err_code=2; later byte_valid pulses produce no writes.
- Restart and reset:
  - After ERROR, start then a good 1-byte frame → done=1 and err_code cleared to 0.
  - n_rst low mid-PAYLOAD → all outputs 0, state IDLE.
  - start pulsed during PAYLOAD → frame completes unaffected.

Source files
------------

// File: rtl/boot_frame_ctrl_if.sv
// Receive-byte and memory-write signal bundle for the boot frame controller.
// The slave modport is the controller; the master modport is its environment.
interface boot_frame_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              rx_timeout;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        err_code;
  logic [15:0]       length;

  modport slave (
    input  start, byte_valid, byte_data, rx_timeout,
    output mem_we, mem_addr, mem_wdata, busy, done, error, err_code, length
  );

  modport master (
    output start, byte_valid, byte_data, rx_timeout,
    input  mem_we, mem_addr, mem_wdata, busy, done, error, err_code, length
  );
endinterface

// File: rtl/boot_frame_ctrl.sv
// Parses a sync/length/payload/checksum boot frame from a UART byte stream into memory.
// Payload writes appear one cycle after each accepted byte; the receiver cannot be stalled.
module boot_frame_ctrl #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned MAX_LEN   = 256,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input logic              clk,
  input logic              n_rst,
  boot_frame_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t            state;
  logic [7:0]        len_lo;
  logic [15:0]       length_q;
  logic [ADDR_W:0]   index;
  logic [7:0]        csum;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [1:0]        err_code_q;

  logic [15:0] len_full;
  logic        len_ok;
  logic [16:0] idx_next;
  logic        last_byte;
  logic [7:0]  csum_fin;

  always_comb begin
    len_full  = {bus.byte_data, len_lo};
    len_ok    = (len_full != 16'd0) && ({16'd0, len_full} <= MAX_LEN);
    // index is one bit wider than the address so a full-memory length still compares
    idx_next  = 17'(index) + 17'd1;
    last_byte = (idx_next == {1'b0, length_q});
    csum_fin  = csum + bus.byte_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= S_IDLE;
      len_lo      <= 8'd0;
      length_q    <= 16'd0;
      index       <= '0;
      csum        <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      mem_we_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start) begin
            state      <= S_SYNC;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'd0;
          end
        end
        S_SYNC: begin
          if (bus.byte_valid && bus.byte_data == SYNC_BYTE) state <= S_LEN_LO;
        end
        default: begin
          // Timeout outranks a byte arriving in the same cycle; that byte is dropped.
          if (bus.rx_timeout) begin
            state      <= S_ERROR;
            busy_q     <= 1'b0;
            error_q    <= 1'b1;
            err_code_q <= 2'd2;
          end else if (bus.byte_valid) begin
            case (state)
              S_LEN_LO: begin
                len_lo <= bus.byte_data;
                state  <= S_LEN_HI;
              end
              S_LEN_HI: begin
                length_q <= len_full;
                if (len_ok) begin
                  state <= S_PAYLOAD;
                  index <= '0;
                  csum  <= 8'd0;
                end else begin
                  state      <= S_ERROR;
                  busy_q     <= 1'b0;
                  error_q    <= 1'b1;
                  err_code_q <= 2'd1;
                end
              end
              S_PAYLOAD: begin
                mem_we_q    <= 1'b1;
                mem_addr_q  <= index[ADDR_W-1:0];
                mem_wdata_q <= bus.byte_data;
                csum        <= csum_fin;
                index       <= idx_next[ADDR_W:0];
                if (last_byte) state <= S_CSUM;
              end
              S_CSUM: begin
                busy_q <= 1'b0;
                if (csum_fin == 8'd0) begin
                  state  <= S_DONE;
                  done_q <= 1'b1;
                end else begin
                  state      <= S_ERROR;
                  error_q    <= 1'b1;
                  err_code_q <= 2'd3;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.err_code  = err_code_q;
  assign bus.length    = length_q;

endmodule

// File: tb/tb_boot_frame_ctrl.sv
// Directed bench for boot_frame_ctrl: frames from a byte table, write log checked against hand values.
module tb_boot_frame_ctrl;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] wr_a[$];
  logic [7:0] wr_d[$];

  boot_frame_ctrl_if #(.ADDR_W(8)) bus();

  boot_frame_ctrl #(.ADDR_W(8), .MAX_LEN(256), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus)
  );

  always #500 clk = ~clk;

  always @(negedge clk) begin
    if (n_rst && bus.mem_we) begin
      wr_a.push_back(bus.mem_addr);
      wr_d.push_back(bus.mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tick(1);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    tick(1);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    tick(1);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] bl[$]);
    foreach (bl[i]) send(bl[i]);
  endtask

  task automatic new_frame();
    wr_a.delete();
    wr_d.delete();
    pulse_start();
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic [1:0] c);
    tick(2);
    check({tag, "_done"}, bus.done, d);
    check({tag, "_error"}, bus.error, e);
    check({tag, "_code"}, bus.err_code, c);
    check({tag, "_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    bus.rx_timeout = 1'b0;
    #2200;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0);
    check("rst_code", bus.err_code, 0);
    check("rst_len", bus.length, 0);
    check("rst_we", bus.mem_we, 0);
    n_rst = 1'b1;

    // bytes in IDLE are ignored
    send(8'hA5); send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    tick(1);
    check("idle_nwr", wr_a.size(), 0);
    check("idle_busy", bus.busy, 0);

    // good frame
    new_frame();
    check("good_busy", bus.busy, 1);
    send_list('{8'hA5, 8'h03, 8'h00, 8'h10, 8'h20, 8'h30, 8'hA0});
    check_status("good", 1, 0, 0);
    check("good_len", bus.length, 3);
    check("good_nwr", wr_a.size(), 3);
    check("good_w0", {wr_a[0], wr_d[0]}, 16'h0010);
    check("good_w1", {wr_a[1], wr_d[1]}, 16'h0120);
    check("good_w2", {wr_a[2], wr_d[2]}, 16'h0230);

    // sync hunt
    new_frame();
    send_list('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h7F, 8'h81});
    check_status("hunt", 1, 0, 0);
    check("hunt_nwr", wr_a.size(), 1);
    check("hunt_w0", {wr_a[0], wr_d[0]}, 16'h007F);

    // bad checksum
    new_frame();
    send_list('{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h00});
    check_status("csum", 0, 1, 3);
    check("csum_nwr", wr_a.size(), 2);

    // bad lengths
    new_frame();
    send_list('{8'hA5, 8'h01, 8'h01});
    check_status("len257", 0, 1, 1);
    check("len257_nwr", wr_a.size(), 0);
    new_frame();
    send_list('{8'hA5, 8'h00, 8'h00});
    check_status("len0", 0, 1, 1);

    // maximum length: payload 0..255, sum = 0x80
    new_frame();
    send_list('{8'hA5, 8'h00, 8'h01});
    for (int i = 0; i < 256; i++) send(8'(i));
    send(8'h80);
    check_status("max", 1, 0, 0);
    check("max_len", bus.length, 256);
    check("max_nwr", wr_a.size(), 256);
    check("max_w0", {wr_a[0], wr_d[0]}, 16'h0000);
    check("max_w255", {wr_a[255], wr_d[255]}, 16'hFFFF);

    // timeout colliding with a payload byte
    new_frame();
    send_list('{8'hA5, 8'h04, 8'h00, 8'h11});
    tick(1);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h22;
    bus.rx_timeout = 1'b1;
    tick(1);
    bus.byte_valid = 1'b0;
    bus.rx_timeout = 1'b0;
    send(8'h33); send(8'h44);
    check_status("tmo", 0, 1, 2);
    check("tmo_nwr", wr_a.size(), 1);
    check("tmo_w0", {wr_a[0], wr_d[0]}, 16'h0011);

    // restart after error; timeout in SYNC is ignored
    new_frame();
    bus.rx_timeout = 1'b1;
    tick(1);
    bus.rx_timeout = 1'b0;
    check("rst_clr_err", bus.error, 0);
    send_list('{8'hA5, 8'h01, 8'h00, 8'h55, 8'hAB});
    check_status("restart", 1, 0, 0);
    check("restart_w0", {wr_a[0], wr_d[0]}, 16'h0055);

    // start during payload is ignored
    new_frame();
    send_list('{8'hA5, 8'h02, 8'h00, 8'h01});
    pulse_start();
    send_list('{8'h02, 8'hFD});
    check_status("midstart", 1, 0, 0);
    check("midstart_nwr", wr_a.size(), 2);
    check("midstart_w1", {wr_a[1], wr_d[1]}, 16'h0102);

    // reset mid-payload
    new_frame();
    send_list('{8'hA5, 8'h03, 8'h00, 8'h01});
    #100;
    n_rst = 1'b0;
    #10;
    check("mrst_busy", bus.busy, 0);
    check("mrst_done", bus.done, 0);
    check("mrst_len", bus.length, 0);
    check("mrst_addr", bus.mem_addr, 0);
    check("mrst_wdata", bus.mem_wdata, 0);
    tick(1);
    n_rst = 1'b1;
    wr_a.delete();
    wr_d.delete();
    send(8'h02); send(8'h03);
    tick(2);
    check("mrst_nwr", wr_a.size(), 0);
    check("mrst_idle", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
